if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage LoongArch pipeline; it is the consumer end of the writeback redirect interface (wb_ex, wb_ertn, csr_eentry, csr_era) and of the ID branch bus.
- Generates fetch PCs and issues requests on the inst SRAM req/addr_ok/data_ok interface.
- Holds each returned instruction and hands it to ID through fs_to_ds_valid/fs_to_ds_bus.
- Squashes wrong-path fetches on exception, ertn and taken branch.

Parameters:
RESET_PC, 32'h1c000000, first fetch address after reset

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ds_allowin  in  1  ID can accept an instruction this cycle
br_bus  in  33  {br_taken, br_target[31:0]} from ID
wb_ex  in  1  exception committed in WB
csr_eentry  in  32  exception entry address
wb_ertn  in  1  ertn committed in WB
csr_era  in  32  ertn return address
inst_sram_req  out  1  fetch request valid
inst_sram_addr  out  32  fetch address
inst_sram_addr_ok  in  1  request accepted
inst_sram_data_ok  in  1  read data returned
inst_sram_rdata  in  32  instruction word
fs_to_ds_valid  out  1  instruction valid to ID
fs_to_ds_bus  out  65  {adef, inst[31:0], pc[31:0]}

Behaviour:
- Interface: clk and reset as named; one clock; reset is synchronous and active-high.
- flush = wb_ex | wb_ertn | br_taken.
  - Target priority: wb_ex → csr_eentry, else wb_ertn → csr_era, else br_target.
- Registers:
  - issue_pc: next sequential address, reset RESET_PC.
  - fs_pc, fs_inst, fs_adef.
  - discard flag, reset 0.
  - FSM, reset IDLE.
- Request address: inst_sram_addr = flush ? target : issue_pc. Combinational, so a redirect is fetched the same cycle.
- inst_sram_req = ~reset & (IDLE | (HOLD & ds_allowin) | (HOLD & flush)). At most one request outstanding.
- On req & addr_ok: fs_pc <= inst_sram_addr, issue_pc <= inst_sram_addr + 4 (mod 2^32, wrap allowed), next state WAIT.
- On flush without an accepted request: issue_pc <= target.
- FSM:
  - IDLE:
    - addr_ok → WAIT.
    - Otherwise stay; addr/req are held stable until accepted, except when a flush changes the target.
  - WAIT:
    - data_ok & ~discard & ~flush → fs_inst <= rdata, HOLD.
    - data_ok & (discard | flush) → drop data, clear discard, IDLE.
    - flush without data_ok → discard <= 1, stay WAIT.
  - HOLD:
    - fs_to_ds_valid = ~flush. The held instruction is squashed in the same cycle as a flush.
    - ds_allowin | flush: release; addr_ok → WAIT, else → IDLE.
    - Otherwise stay; bus stable.
- Back-to-back fetch: HOLD→WAIT via the same-cycle handoff+request gives 2 cycles/instruction with 1-cycle SRAM.
- Simultaneous events:
  - wb_ex with br_taken: wb_ex wins.
  - flush with data_ok in WAIT: data dropped, no discard set.
  - flush in IDLE with addr_ok: target accepted directly.
- Reset mid-operation: FSM→IDLE, discard←0, req←0, issue_pc←RESET_PC. The SRAM interface shares this reset, so no stale data_ok follows.
- Output reset values: inst_sram_req=0, fs_to_ds_valid=0, fs_to_ds_bus=0.

Optional Feature:
- Macro: IF_ADEF_CHECK_EN.
- Defined:
  - A request address with addr[1:0] != 0 asserts no req.
  - FSM goes IDLE→HOLD directly with fs_adef=1, fs_inst=0, fs_pc=addr.
  - issue_pc is unchanged; WB raises ADEF.
- Undefined: fs_adef is tied 0 and misaligned addresses are fetched normally.

Decomposition:
- Shared package `pipe_pkg`:
  - RESET_PC.
  - FS_TO_DS_BUS_WD=65, BR_BUS_WD=33.
  - FSM state encoding: IDLE=2'd0, WAIT=2'd1, HOLD=2'd2.
- Natural sub-module `fetch_redirect`: combinational flush/target priority mux plus the discard flag register.

Test Plan:
- Release reset, SRAM 1-cycle latency, ds_allowin=1:
  - First req addr = 0x1c000000.
  - Fetch PCs 0x1c000000, 0x1c000004, 0x1c000008 appear every 2 cycles, with matching rdata.
- ds_allowin=0 for 5 cycles while in HOLD (pc 0x1c000004): fs_to_ds_bus stable, no new req; on release, req addr 0x1c000008 issues the same cycle.
- Flush during an outstanding fetch:
  - Request 0x1c000010 accepted, data_ok delayed 3 cycles; wb_ex=1 with csr_eentry=0x1c008000 in WAIT.
  - Returned data is dropped (fs_to_ds_valid stays 0).
  - Next req addr = 0x1c008000.
- Simultaneous redirects: wb_ex and br_taken (target 0x1c000100) in the same cycle, plus wb_ertn alone with csr_era=0x1c000040:
  - eentry is fetched for the wb_ex case.
  - Then ertn fetches 0x1c000040.
- Misaligned target (with IF_ADEF_CHECK_EN): br_taken with target 0x1c000102 → no req; fs_to_ds_bus = {1, 0, 0x1c000102}, valid next cycle.
- Reset asserted in WAIT with discard=1: next cycle req=0, valid=0; after release req addr = 0x1c000000.

Source files
------------

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the 5-stage pipeline front end:
//   RESET_PC         first fetch address after reset
//   FS_TO_DS_BUS_WD  width of the IF->ID bus {adef, inst, pc}
//   BR_BUS_WD        width of the ID->IF branch bus {br_taken, br_target}
//   fs_state_e       fetch-stage FSM encoding (IDLE / WAIT / HOLD)
//   addr_misaligned  helper: instruction address not word aligned
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam logic [31:0] RESET_PC        = 32'h1c00_0000;
  localparam int          FS_TO_DS_BUS_WD = 65;
  localparam int          BR_BUS_WD       = 33;

  // IDLE: ready to issue; WAIT: one request outstanding; HOLD: instruction held for ID
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fs_state_e;

  function automatic logic addr_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// -----------------------------------------------------------------------------
// if_stage_if
// Instruction SRAM request/response channel (req/addr_ok/data_ok protocol).
//   req      master->slave  fetch request valid
//   addr     master->slave  fetch address
//   addr_ok  slave->master  request accepted this cycle
//   data_ok  slave->master  read data returned this cycle
//   rdata    slave->master  instruction word
// Modports: master (fetch stage), slave (SRAM / bus bridge).
// -----------------------------------------------------------------------------
interface if_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (output req, addr, input addr_ok, data_ok, rdata);
  modport slave  (input req, addr, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/fetch_redirect.sv
// -----------------------------------------------------------------------------
// fetch_redirect
// Redirect selection for the fetch stage plus the discard flag.
//   clk, reset            clock, synchronous active-high reset
//   wb_ex, csr_eentry     exception redirect (highest priority)
//   wb_ertn, csr_era      ertn redirect
//   br_bus                {br_taken, br_target} from ID (lowest priority)
//   in_wait, data_ok      fetch FSM is waiting / SRAM returned data
//   flush, target         redirect request and its address
//   discard               the outstanding fetch belongs to a squashed path
// -----------------------------------------------------------------------------
module fetch_redirect
  import pipe_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wb_ex,
  input  logic [31:0]          csr_eentry,
  input  logic                 wb_ertn,
  input  logic [31:0]          csr_era,
  input  logic [BR_BUS_WD-1:0] br_bus,
  input  logic                 in_wait,
  input  logic                 data_ok,
  output logic                 flush,
  output logic [31:0]          target,
  output logic                 discard
);

  logic        br_taken;
  logic [31:0] br_target;
  logic        discard_reg;

  assign {br_taken, br_target} = br_bus;
  assign flush = wb_ex | wb_ertn | br_taken;

  always_comb begin
    target = br_target;
    if (wb_ex)        target = csr_eentry;
    else if (wb_ertn) target = csr_era;
  end

  // Set when a flush hits an in-flight fetch before its data arrives; the
  // returning data_ok then consumes the flag. A flush coinciding with data_ok
  // drops that data directly, so the flag is not needed in that case.
  always_ff @(posedge clk) begin
    if (reset) begin
      discard_reg <= 1'b0;
    end else if (in_wait && data_ok) begin
      discard_reg <= 1'b0;
    end else if (in_wait && flush) begin
      discard_reg <= 1'b1;
    end
  end

  assign discard = discard_reg;

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage: generates fetch PCs, issues them on the inst SRAM
// channel (one request outstanding), holds the returned instruction for ID and
// squashes wrong-path fetches on exception, ertn and taken branch.
//   clk, reset        clock, synchronous active-high reset
//   ds_allowin        ID can accept an instruction this cycle
//   br_bus            {br_taken, br_target} from ID
//   wb_ex/csr_eentry  exception redirect from WB
//   wb_ertn/csr_era   ertn redirect from WB
//   inst_sram         SRAM channel (if_stage_if.master)
//   fs_to_ds_valid    instruction valid to ID
//   fs_to_ds_bus      {adef, inst, pc}
// Optional build macro IF_ADEF_CHECK_EN: misaligned fetch addresses are not
// sent to the SRAM; the stage presents an ADEF-marked bubble instead.
// -----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = pipe_pkg::RESET_PC
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 ds_allowin,
  input  logic [pipe_pkg::BR_BUS_WD-1:0]       br_bus,
  input  logic                                 wb_ex,
  input  logic [31:0]                          csr_eentry,
  input  logic                                 wb_ertn,
  input  logic [31:0]                          csr_era,
  if_stage_if.master                           inst_sram,
  output logic                                 fs_to_ds_valid,
  output logic [pipe_pkg::FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus
);
  import pipe_pkg::*;

  fs_state_e   state_reg, state_next;
  logic [31:0] issue_pc_reg;
  logic [31:0] fs_pc_reg;
  logic [31:0] fs_inst_reg;
  logic        fs_adef;

  logic        flush;
  logic [31:0] target;
  logic        discard;
  logic [31:0] fetch_addr;
  logic        addr_bad;
  logic        req_cand;
  logic        accepted;
  logic        adef_take;
  logic        in_wait;
  logic        take_data;

  assign in_wait = (state_reg == WAIT);

  fetch_redirect u_redirect (
    .clk        (clk),
    .reset      (reset),
    .wb_ex      (wb_ex),
    .csr_eentry (csr_eentry),
    .wb_ertn    (wb_ertn),
    .csr_era    (csr_era),
    .br_bus     (br_bus),
    .in_wait    (in_wait),
    .data_ok    (inst_sram.data_ok),
    .flush      (flush),
    .target     (target),
    .discard    (discard)
  );

  // A redirect is presented to the SRAM in the same cycle it arrives.
  assign fetch_addr = flush ? target : issue_pc_reg;

`ifdef IF_ADEF_CHECK_EN
  assign addr_bad = addr_misaligned(fetch_addr);
`else
  assign addr_bad = 1'b0;
`endif

  // HOLD may issue as soon as its instruction leaves (or is squashed), which
  // gives back-to-back fetch at 2 cycles/instruction with a 1-cycle SRAM.
  assign req_cand = (state_reg == IDLE) ||
                    ((state_reg == HOLD) && (ds_allowin || flush));

  assign inst_sram.req  = ~reset & req_cand & ~addr_bad;
  assign inst_sram.addr = fetch_addr;

  assign accepted  = inst_sram.req & inst_sram.addr_ok;
  assign adef_take = ~reset & (state_reg == IDLE) & addr_bad;
  assign take_data = in_wait & inst_sram.data_ok & ~discard & ~flush;

  always_comb begin
    state_next     = state_reg;
    fs_to_ds_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accepted)       state_next = WAIT;
        else if (adef_take) state_next = HOLD;
      end
      WAIT: begin
        if (inst_sram.data_ok) state_next = (discard || flush) ? IDLE : HOLD;
      end
      HOLD: begin
        fs_to_ds_valid = ~reset & ~flush;
        if (ds_allowin || flush) state_next = accepted ? WAIT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      issue_pc_reg <= RESET_PC;
      fs_pc_reg    <= 32'h0;
      fs_inst_reg  <= 32'h0;
    end else begin
      state_reg <= state_next;
      if (accepted) begin
        fs_pc_reg    <= fetch_addr;
        issue_pc_reg <= fetch_addr + 32'd4;
      end else if (adef_take) begin
        // Bad address is reported through the bus; issue_pc keeps its value.
        fs_pc_reg   <= fetch_addr;
        fs_inst_reg <= 32'h0;
      end else if (flush) begin
        issue_pc_reg <= target;
      end
      if (take_data) fs_inst_reg <= inst_sram.rdata;
    end
  end

`ifdef IF_ADEF_CHECK_EN
  logic fs_adef_reg;
  always_ff @(posedge clk) begin
    if (reset)          fs_adef_reg <= 1'b0;
    else if (accepted)  fs_adef_reg <= 1'b0;
    else if (adef_take) fs_adef_reg <= 1'b1;
  end
  assign fs_adef = fs_adef_reg;
`else
  assign fs_adef = 1'b0;
`endif

  assign fs_to_ds_bus = {fs_adef, fs_inst_reg, fs_pc_reg};

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
  import pipe_pkg::*;

  localparam logic [31:0] B   = 32'h1c00_0000;
  localparam logic [31:0] EEN = 32'h1c00_8000;
  localparam logic [31:0] ERA = 32'h1c00_0040;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_allowin;
  logic [32:0] br_bus;
  logic        wb_ex;
  logic [31:0] csr_eentry;
  logic        wb_ertn;
  logic [31:0] csr_era;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;

  if_stage_if inst_sram_bus ();

  if_stage #(.RESET_PC(B)) dut (
    .clk            (clk),
    .reset          (reset),
    .ds_allowin     (ds_allowin),
    .br_bus         (br_bus),
    .wb_ex          (wb_ex),
    .csr_eentry     (csr_eentry),
    .wb_ertn        (wb_ertn),
    .csr_era        (csr_era),
    .inst_sram      (inst_sram_bus),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ds;
    logic        wbex;
    logic        ertn;
    logic        br;
    logic [31:0] brt;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [64:0] ebus;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [64:0] bus(input logic adef, input logic [31:0] inst,
                                      input logic [31:0] pc);
    return {adef, inst, pc};
  endfunction

  task automatic add(input logic ds, input logic wbex, input logic ertn, input logic br,
                     input logic [31:0] brt, input logic aok, input logic dok,
                     input logic [31:0] rdata, input logic ereq, input logic [31:0] eaddr,
                     input logic evalid, input logic [64:0] ebus);
    vec_t v;
    v.ds = ds; v.wbex = wbex; v.ertn = ertn; v.br = br; v.brt = brt;
    v.aok = aok; v.dok = dok; v.rdata = rdata;
    v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid; v.ebus = ebus;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [64:0] act,
                     input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic ds, input logic wbex, input logic ertn, input logic br,
                       input logic [31:0] brt, input logic aok, input logic dok,
                       input logic [31:0] rdata);
    ds_allowin            = ds;
    wb_ex                 = wbex;
    wb_ertn               = ertn;
    br_bus                = {br, brt};
    inst_sram_bus.addr_ok = aok;
    inst_sram_bus.data_ok = dok;
    inst_sram_bus.rdata   = rdata;
  endtask

  initial begin
    csr_eentry = EEN;
    csr_era    = ERA;
    reset      = 1'b1;
    drive(1, 0, 0, 0, 0, 1, 0, 0);

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req",   100, inst_sram_bus.req, 1'b0);
    chk("rst_valid", 100, fs_to_ds_valid,    1'b0);
    chk("rst_bus",   100, fs_to_ds_bus,      65'h0);

    // ---------------- table (one entry per cycle) ----------------
    add(1,0,0,0,0,        1,0,0,            1,B,        0,0);                       // 0
    add(1,0,0,0,0,        1,1,32'h1111_1111,0,0,        0,0);                       // 1
    add(1,0,0,0,0,        1,0,0,            1,B+4,      1,bus(0,32'h1111_1111,B));  // 2
    add(1,0,0,0,0,        1,1,32'h2222_2222,0,0,        0,0);                       // 3
    for (int i = 0; i < 5; i++)
      add(0,0,0,0,0,      1,0,0,            0,0,        1,bus(0,32'h2222_2222,B+4));// 4-8
    add(1,0,0,0,0,        1,0,0,            1,B+8,      1,bus(0,32'h2222_2222,B+4));// 9
    add(1,0,0,0,0,        1,1,32'h3333_3333,0,0,        0,0);                       // 10
    add(1,0,0,0,0,        1,0,0,            1,B+12,     1,bus(0,32'h3333_3333,B+8));// 11
    add(1,0,0,0,0,        1,1,32'h4444_4444,0,0,        0,0);                       // 12
    add(1,0,0,0,0,        1,0,0,            1,B+16,     1,bus(0,32'h4444_4444,B+12));// 13
    add(1,0,0,0,0,        1,0,0,            0,0,        0,0);                       // 14 wait
    add(1,1,0,0,0,        1,0,0,            0,0,        0,0);                       // 15 ex in WAIT
    add(1,0,0,0,0,        1,1,32'h5555_5555,0,0,        0,0);                       // 16 dropped
    add(1,0,0,0,0,        1,0,0,            1,EEN,      0,0);                       // 17
    add(1,0,0,0,0,        1,1,32'h6666_6666,0,0,        0,0);                       // 18
    add(0,0,0,0,0,        1,0,0,            0,0,        1,bus(0,32'h6666_6666,EEN));// 19
    add(0,1,0,1,B+32'h100,1,0,0,            1,EEN,      0,0);                       // 20 ex+br
    add(0,0,0,0,0,        1,1,32'h7777_7777,0,0,        0,0);                       // 21
    add(0,0,1,0,0,        0,0,0,            1,ERA,      0,0);                       // 22 ertn in HOLD
    add(1,0,0,0,0,        1,0,0,            1,ERA,      0,0);                       // 23
    add(1,0,0,0,0,        1,1,32'h8888_8888,0,0,        0,0);                       // 24
    add(1,0,0,0,0,        0,0,0,            1,ERA+4,    1,bus(0,32'h8888_8888,ERA));// 25
    add(1,0,0,0,0,        0,0,0,            1,ERA+4,    0,0);                       // 26 req held
    add(1,0,0,0,0,        1,0,0,            1,ERA+4,    0,0);                       // 27
    add(1,0,0,1,B+32'h200,1,1,32'haaaa_aaaa,0,0,        0,0);                       // 28 br+data_ok
    add(1,0,0,0,0,        0,0,0,            1,B+32'h200,0,0);                       // 29
    add(1,0,1,0,0,        1,0,0,            1,ERA,      0,0);                       // 30 ertn+addr_ok
    add(1,0,0,0,0,        1,1,32'h9999_9999,0,0,        0,0);                       // 31
    add(1,0,0,0,0,        1,0,0,            1,ERA+4,    1,bus(0,32'h9999_9999,ERA));// 32
    add(1,1,0,0,0,        1,0,0,            0,0,        0,0);                       // 33 discard set

    foreach (vq[i]) begin
      @(negedge clk);
      reset = 1'b0;
      drive(vq[i].ds, vq[i].wbex, vq[i].ertn, vq[i].br, vq[i].brt,
            vq[i].aok, vq[i].dok, vq[i].rdata);
      #1;
      $display("step %0d req=%0b addr=%h valid=%0b bus=%h", i, inst_sram_bus.req,
               inst_sram_bus.addr, fs_to_ds_valid, fs_to_ds_bus);
      chk("req", i, inst_sram_bus.req, vq[i].ereq);
      if (vq[i].ereq) chk("addr", i, inst_sram_bus.addr, vq[i].eaddr);
      chk("valid", i, fs_to_ds_valid, vq[i].evalid);
      if (vq[i].evalid) chk("bus", i, fs_to_ds_bus, vq[i].ebus);
    end

    // ---------------- reset while WAIT with discard set ----------------
    @(negedge clk);
    reset = 1'b1;
    drive(1, 0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("mid_rst_req", 200, inst_sram_bus.req, 1'b0);
    @(negedge clk);
    #1;
    chk("mid_rst_req2",   201, inst_sram_bus.req, 1'b0);
    chk("mid_rst_valid",  201, fs_to_ds_valid,    1'b0);
    chk("mid_rst_bus",    201, fs_to_ds_bus,      65'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_req",  202, inst_sram_bus.req,  1'b1);
    chk("post_rst_addr", 202, inst_sram_bus.addr, B);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 1, 1, 32'hcccc_cccc);
    #1;
    chk("post_rst_wait", 203, fs_to_ds_valid, 1'b0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    $display("post-reset fetch valid=%0b bus=%h", fs_to_ds_valid, fs_to_ds_bus);
    chk("post_rst_valid", 204, fs_to_ds_valid, 1'b1);
    chk("post_rst_bus",   204, fs_to_ds_bus,   bus(0, 32'hcccc_cccc, B));

`ifdef IF_ADEF_CHECK_EN
    // ---------------- misaligned branch target from IDLE ----------------
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 1, B + 32'h102, 1, 0, 0);
    #1;
    chk("adef_noreq", 300, inst_sram_bus.req, 1'b0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    $display("adef valid=%0b bus=%h", fs_to_ds_valid, fs_to_ds_bus);
    chk("adef_valid", 301, fs_to_ds_valid, 1'b1);
    chk("adef_bus",   301, fs_to_ds_bus,   bus(1, 32'h0, B + 32'h102));
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("adef_next_req",  302, inst_sram_bus.req,  1'b1);
    chk("adef_next_addr", 302, inst_sram_bus.addr, B);
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
